// File: rtl/sm_muldiv.sv
// sm_muldiv: iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division. Each takes
// WIDTH RUN cycles on operand magnitudes, followed by one FIX cycle that applies
// the result signs and writes HI/LO. MTHI/MTLO write directly at the accepting edge.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start, oper     one-cycle operation strobe and opcode (sampled in IDLE only)
//   srcA, srcB      operands (srcA is also the MTHI/MTLO data)
//   busy, done      registered in-flight flag and one-cycle completion pulse
//   hi, lo          HI/LO registers
//   divZero         last completed divide had a zero divisor
module sm_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       oper,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divZero
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opd_q, opd_d;
  logic           is_div_q, is_div_d;
  logic           neg_res_q, neg_res_d;
  logic           neg_rem_q, neg_rem_d;
  logic           dz_pend_q, dz_pend_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic           busy_q, busy_d, done_q, done_d, divzero_q, divzero_d;

  assign busy    = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign divZero = divzero_q;

  // Opcode decode; only meaningful while IDLE.
  logic iter_start, mt_start, signed_op, last_iter;
  logic [W-1:0] a_mag, b_mag;

  assign iter_start = (state_q == S_IDLE) && start && !oper[2];
  assign mt_start   = (state_q == S_IDLE) && start && (oper[2:1] == 2'b10);
  assign signed_op  = !oper[0];
  assign a_mag      = (signed_op && srcA[W-1]) ? -srcA : srcA;
  assign b_mag      = (signed_op && srcB[W-1]) ? -srcB : srcB;
  assign last_iter  = (cnt_q == CW'(W - 1));

  // Shift-add step: add multiplicand to upper half when the multiplier LSB is set, then shift right.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + ({1'b0, opd_q} & {(W+1){acc_q[0]}});
  assign mul_next = {mul_sum, acc_q[W-1:1]};

  // Restoring step: acc holds {remainder, remaining dividend bits / quotient bits}.
  logic [W:0]     div_sh, div_diff;
  logic           div_ge;
  logic [2*W-1:0] div_next;
  assign div_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff = div_sh - {1'b0, opd_q};
  assign div_ge   = !div_diff[W];
  assign div_next = {(div_ge ? div_diff[W-1:0] : div_sh[W-1:0]), acc_q[W-2:0], div_ge};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iter_start) state_d = S_RUN;
      S_RUN:   if (last_iter) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opd_d     = opd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_pend_d = dz_pend_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    divzero_d = divzero_q;
    done_d    = 1'b0;
    busy_d    = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (iter_start) begin
          cnt_d     = '0;
          is_div_d  = oper[1];
          opd_d     = oper[1] ? b_mag : a_mag;
          acc_d     = {{W{1'b0}}, (oper[1] ? a_mag : b_mag)};
          neg_res_d = signed_op && (srcA[W-1] ^ srcB[W-1]);
          neg_rem_d = signed_op && srcA[W-1];
          dz_pend_d = oper[1] && (srcB == '0);
          divzero_d = 1'b0;
        end else if (mt_start) begin
          divzero_d = 1'b0;
          done_d    = 1'b1;
          if (oper[0]) lo_d = srcA;
          else         hi_d = srcA;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        acc_d = is_div_q ? div_next : mul_next;
      end
      S_FIX: begin
        done_d = 1'b1;
        if (is_div_q) begin
          // With a zero divisor the remainder path already holds the dividend magnitude,
          // so re-applying the dividend sign restores the original srcA bits.
          hi_d      = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
          lo_d      = dz_pend_q ? {W{1'b1}}
                                : (neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0]);
          divzero_d = dz_pend_q;
        end else begin
          {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opd_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_pend_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opd_q     <= opd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_pend_q <= dz_pend_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

endmodule

// File: tb/tb_sm_muldiv.sv
// tb_sm_muldiv: scoreboard bench for sm_muldiv at WIDTH=32 and WIDTH=8.
// Expected HI/LO/divZero are queued when an operation is issued and compared
// when the matching DUT raises done.
module tb_sm_muldiv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start32, busy32, done32, dz32;
  logic [2:0]  oper32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start8, busy8, done8, dz8;
  logic [2:0]  oper8;
  logic [7:0]  a8, b8, hi8, lo8;

  sm_muldiv #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .oper(oper32), .srcA(a32), .srcB(b32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .divZero(dz32));

  sm_muldiv #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .oper(oper8), .srcA(a8), .srcB(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .divZero(dz8));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    string       tag;
  } exp_t;

  exp_t        q32[$], q8[$];
  exp_t        e32, e8;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi32, m_lo32, m_hi8, m_lo8;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference model built on native 64-bit arithmetic (truncating / and %).
  function automatic void model(input int w, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] h,
                                output logic [31:0] l, output logic dz);
    longint      sa, sb, p, q, r;
    logic [63:0] mask, pu;
    mask = (64'd1 << w) - 64'd1;
    sa = (!op[0] && a[w-1]) ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = (!op[0] && b[w-1]) ? longint'(b) - (longint'(1) << w) : longint'(b);
    dz = 1'b0;
    if (!op[1]) begin
      p  = sa * sb;
      pu = p;
      h  = 32'((pu >> w) & mask);
      l  = 32'(pu & mask);
    end else if (b == 32'd0) begin
      dz = 1'b1;
      h  = a;
      l  = 32'(mask);
    end else begin
      q = sa / sb;
      r = sa % sb;
      h = 32'(64'(r) & mask);
      l = 32'(64'(q) & mask);
    end
  endfunction

  // Scoreboard monitors.
  always @(negedge clk) begin
    if (done32) begin
      if (q32.size() == 0) check_eq("unexpected_done32", 64'(done32), 64'd0);
      else begin
        e32 = q32.pop_front();
        check_eq({e32.tag, "_hi"}, 64'(hi32), 64'(e32.hi));
        check_eq({e32.tag, "_lo"}, 64'(lo32), 64'(e32.lo));
        check_eq({e32.tag, "_dz"}, 64'(dz32), 64'(e32.dz));
      end
    end
  end

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) check_eq("unexpected_done8", 64'(done8), 64'd0);
      else begin
        e8 = q8.pop_front();
        check_eq({e8.tag, "_hi"}, 64'(hi8), 64'(e8.hi));
        check_eq({e8.tag, "_lo"}, 64'(lo8), 64'(e8.lo));
        check_eq({e8.tag, "_dz"}, 64'(dz8), 64'(e8.dz));
      end
    end
  end

  task automatic push32(input logic [31:0] h, input logic [31:0] l, input logic dz, input string tag);
    q32.push_back('{hi: h, lo: l, dz: dz, tag: tag});
    m_hi32 = h;
    m_lo32 = l;
  endtask

  task automatic push8(input logic [31:0] h, input logic [31:0] l, input logic dz, input string tag);
    q8.push_back('{hi: h, lo: l, dz: dz, tag: tag});
    m_hi8 = h;
    m_lo8 = l;
  endtask

  // Drive a one-cycle start; operands are scrambled afterwards to prove they were latched.
  task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start32 = 1'b1; oper32 = op; a32 = a; b32 = b;
    @(negedge clk);
    start32 = 1'b0; a32 = $urandom; b32 = $urandom;
  endtask

  task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start8 = 1'b1; oper8 = op; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  // Bounded wait for done; lat counts negedges from the one after the start edge.
  task automatic wait32(output int lat, output int bcnt, output bit stable);
    logic [31:0] h0, l0;
    lat = 1; bcnt = int'(busy32); h0 = hi32; l0 = lo32; stable = 1'b1;
    while (!done32 && lat < 200) begin
      @(negedge clk);
      lat++;
      bcnt += int'(busy32);
      if (!done32 && (hi32 !== h0 || lo32 !== l0)) stable = 1'b0;
    end
    if (!done32) check_eq("timeout32", 64'(done32), 64'd1);
  endtask

  task automatic wait8(output int lat, output int bcnt, output bit stable);
    logic [7:0] h0, l0;
    lat = 1; bcnt = int'(busy8); h0 = hi8; l0 = lo8; stable = 1'b1;
    while (!done8 && lat < 200) begin
      @(negedge clk);
      lat++;
      bcnt += int'(busy8);
      if (!done8 && (hi8 !== h0 || lo8 !== l0)) stable = 1'b0;
    end
    if (!done8) check_eq("timeout8", 64'(done8), 64'd1);
  endtask

  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] h, input logic [31:0] l, input logic dz, input string tag);
    int lat, bcnt;
    bit stable;
    push32(h, l, dz, tag);
    issue32(op, a, b);
    check_eq({tag, "_dzclr"}, 64'(dz32), 64'd0);
    wait32(lat, bcnt, stable);
    if (!op[2]) begin
      check_eq({tag, "_lat"}, 64'(lat), 64'd34);
      check_eq({tag, "_busycyc"}, 64'(bcnt), 64'd33);
      check_eq({tag, "_stable"}, 64'(stable), 64'd1);
    end else begin
      check_eq({tag, "_lat"}, 64'(lat), 64'd1);
      check_eq({tag, "_busycyc"}, 64'(bcnt), 64'd0);
    end
  endtask

  task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [31:0] h, input logic [31:0] l, input logic dz, input string tag);
    int lat, bcnt;
    bit stable;
    push8(h, l, dz, tag);
    issue8(op, a, b);
    wait8(lat, bcnt, stable);
    check_eq({tag, "_lat"}, 64'(lat), 64'd10);
    check_eq({tag, "_busycyc"}, 64'(bcnt), 64'd9);
    check_eq({tag, "_stable"}, 64'(stable), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h, l, ra, rb;
    logic        dz;
    logic [2:0]  op;
    int          lat, bcnt, dcnt;
    bit          stable;

    rst_n = 1'b0;
    start32 = 1'b0; oper32 = 3'd0; a32 = '0; b32 = '0;
    start8  = 1'b0; oper8  = 3'd0; a8  = '0; b8  = '0;
    m_hi32 = '0; m_lo32 = '0; m_hi8 = '0; m_lo8 = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_hi", 64'(hi32), 64'd0);
    check_eq("rst_lo", 64'(lo32), 64'd0);
    check_eq("rst_busy", 64'(busy32), 64'd0);
    check_eq("rst_done", 64'(done32), 64'd0);
    check_eq("rst_dz", 64'(dz32), 64'd0);
    rst_n = 1'b1;

    // Directed WIDTH=32 cases.
    run32(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
    run32(3'b000, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_m3x7");
    run32(3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, "mult_minmin");
    run32(3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_m7d2");
    run32(3'b010, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div_7dm2");
    run32(3'b011, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, "divu_100d7");
    run32(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_ovf");
    run32(3'b010, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, "div_m7d0");
    run32(3'b011, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1, "divu_d0");
    repeat (3) @(negedge clk);
    check_eq("dz_held", 64'(dz32), 64'd1);

    // MTHI/MTLO leave the other register alone.
    run32(3'b100, 32'hA5A5_A5A5, 32'd0, 32'hA5A5_A5A5, m_lo32, 1'b0, "mthi");
    run32(3'b101, 32'h5A5A_5A5A, 32'd0, m_hi32, 32'h5A5A_5A5A, 1'b0, "mtlo");

    // Reserved opcode: no done, no busy, HI/LO untouched.
    issue32(3'b110, 32'h1111_1111, 32'h2222_2222);
    dcnt = int'(done32) + int'(busy32);
    repeat (3) begin
      @(negedge clk);
      dcnt += int'(done32) + int'(busy32);
    end
    check_eq("rsvd_activity", 64'(dcnt), 64'd0);
    check_eq("rsvd_hi", 64'(hi32), 64'(m_hi32));
    check_eq("rsvd_lo", 64'(lo32), 64'(m_lo32));

    // Start while busy is ignored.
    push32(32'd0, 32'd30, 1'b0, "busy_ign");
    issue32(3'b001, 32'd5, 32'd6);
    repeat (2) @(negedge clk);
    start32 = 1'b1; oper32 = 3'b011; a32 = 32'd9; b32 = 32'd3;
    @(negedge clk);
    start32 = 1'b0;
    wait32(lat, bcnt, stable);
    repeat (3) @(negedge clk);

    // Reset mid-operation aborts; a start sampled during reset is discarded.
    issue32(3'b010, 32'hFFFF_FFF9, 32'd2);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    start32 = 1'b1; oper32 = 3'b001; a32 = 32'd3; b32 = 32'd4;
    @(negedge clk);
    check_eq("midrst_hi", 64'(hi32), 64'd0);
    check_eq("midrst_lo", 64'(lo32), 64'd0);
    check_eq("midrst_busy", 64'(busy32), 64'd0);
    check_eq("midrst_done", 64'(done32), 64'd0);
    check_eq("midrst_dz", 64'(dz32), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; start32 = 1'b0;
    m_hi32 = '0; m_lo32 = '0;
    @(negedge clk);
    check_eq("rst_start_drop", 64'(busy32), 64'd0);
    run32(3'b001, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, "multu_3x4");

    // Randomised WIDTH=32 operations against the reference model.
    for (int i = 0; i < 6; i++) begin
      op = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
      model(32, op, ra, rb, h, l, dz);
      run32(op, ra, rb, h, l, dz, $sformatf("rnd32_%0d", i));
    end

    // WIDTH=8 signed corner cases and random operations.
    run8(3'b010, 8'h80, 8'hFF, 32'h00, 32'h80, 1'b0, "w8_div_ovf");
    run8(3'b000, 8'h80, 8'h80, 32'h40, 32'h00, 1'b0, "w8_mult_minmin");
    run8(3'b000, 8'hFD, 8'h07, 32'hFF, 32'hEB, 1'b0, "w8_mult_m3x7");
    run8(3'b010, 8'hF9, 8'h02, 32'hFF, 32'hFD, 1'b0, "w8_div_m7d2");
    run8(3'b010, 8'hF9, 8'h00, 32'hF9, 32'hFF, 1'b1, "w8_div_d0");
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 3));
      ra = 32'($urandom_range(0, 255));
      rb = 32'($urandom_range(0, 255));
      model(8, op, ra, rb, h, l, dz);
      run8(op, 8'(ra), 8'(rb), h, l, dz, $sformatf("rnd8_%0d", i));
    end

    repeat (3) @(negedge clk);
    check_eq("q32_drained", 64'(q32.size()), 64'd0);
    check_eq("q8_drained", 64'(q8.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sm_muldiv.md
# sm_muldiv

Iterative multi-cycle multiply/divide unit for the schoolMIPS core. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO against architectural HI/LO registers of parameterised width. It sits beside the single-cycle ALU: the core issues an operation with a one-cycle `start` strobe and stalls on `busy` (or waits for `done`) before reading HI/LO.

## Interface

Parameters:

- `WIDTH`, 32: operand and HI/LO width; legal values ≥ 2.

Ports:

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  operation strobe; sampled only in IDLE.
- `oper`  in  3  opcode: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
- `srcA`  in  WIDTH  multiplicand / dividend / MTHI-MTLO data.
- `srcB`  in  WIDTH  multiplier / divisor.
- `busy`  out  1  high while an iterative operation is in flight.
- `done`  out  1  one-cycle pulse: HI/LO were just updated.
- `hi`  out  WIDTH  HI register: product upper half, or remainder.
- `lo`  out  WIDTH  LO register: product lower half, or quotient.
- `divZero`  out  1  last completed DIV/DIVU had divisor 0; held until the next accepted start.

## Operation

- **State machine:** IDLE, RUN, FIX.
  - IDLE→RUN on `start` with oper 000–011.
  - RUN→FIX after exactly WIDTH iterations.
  - FIX→IDLE unconditionally.
- **Accepted start:** an edge in IDLE with `start`=1. At that edge:
  - latch operand magnitudes (abs value for signed ops, raw for unsigned);
  - latch result signs;
  - clear the iteration counter (width $clog2(WIDTH+1));
  - clear `divZero`.
- **MTHI / MTLO:** complete at the accepting edge.
  - `hi` (MTHI) or `lo` (MTLO) is loaded with `srcA`; the other register is unchanged.
  - `done` pulses the next cycle; `busy` never rises.
- **Reserved opcodes:** `start` is ignored, with no `done` and no state change.
- **Multiply:** shift-add, one multiplier bit per RUN cycle, into a 2×WIDTH accumulator.
  - In FIX the product is negated if the op is signed and sign(srcA) ≠ sign(srcB).
  - {hi,lo} ← product.
- **Divide:** restoring, one quotient bit per RUN cycle.
  - In FIX, for signed ops: the quotient is negated if the signs differ; the remainder takes the sign of the dividend (truncating division).
  - lo ← quotient, hi ← remainder.
- **Divide by zero (srcB=0):**
  - hi ← srcA (original, unsigned-interpreted bits);
  - lo ← all ones;
  - `divZero`=1.
  - Full latency is still taken.
- **Signed overflow (DIV, most-negative / −1):** lo ← most-negative value, hi ← 0. This falls out of the magnitude algorithm and needs no special case.
- **Start while busy:** ignored. The in-flight operation and its operands are not disturbed.
- **HI/LO write timing:** the registers are written only at the FIX edge (or the MTHI/MTLO edge). They hold their previous values throughout RUN.

## Timing

- **Reset values:** state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, `divZero`=0, internal accumulators 0.
- **Reset mid-operation:** `rst_n` low at any edge aborts the operation.
  - All outputs take their reset values at that edge.
  - No partial HI/LO write occurs.
  - A start sampled together with `rst_n`=0 is discarded.
- **Iterative latency:** with the accepting edge as E0:
  - RUN iterations occur at E1..E_WIDTH;
  - FIX writes HI/LO at E_(WIDTH+1).
- **busy:** high from after E0 through E_(WIDTH+1); low in the cycle after E_(WIDTH+1).
- **done:** high for exactly the one cycle after E_(WIDTH+1), coincident with `busy` falling. For WIDTH=32, `done` is high in cycle 34 counting E0's cycle as 1.
- **Back-to-back:** a new start is accepted at the edge ending the `done` cycle; one idle-sampling cycle follows each op.
- **Stall interface:** `busy` is a registered output; the core may combine it with its own decode to stall.
- **Output stability:** `hi`/`lo` change only at the writing edge; they are stable in every other cycle.

## Test plan

- **MULTU, WIDTH=32:** 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. `done` exactly WIDTH+1 edges after the start edge; `busy` high for 33 cycles.
- **MULT −3 × 7:** → hi=0xFFFFFFFF, lo=0xFFFFFFEB. **MULT 0x80000000 × 0x80000000:** → hi=0x40000000, lo=0.
- **DIV −7 / 2:** → lo=0xFFFFFFFD, hi=0xFFFFFFFF. **DIVU 100 / 7:** → lo=14, hi=2. **DIV 0x80000000 / 0xFFFFFFFF:** → lo=0x80000000, hi=0.
- **DIVU 0x1234 / 0:** → hi=0x1234, lo=0xFFFFFFFF, `divZero`=1. `divZero` stays 1 until the next accepted start, then clears.
- **Start while busy:** start MULTU 5×6; at cycle 5 pulse `start` with DIVU 9/3 → ignored, result hi=0, lo=30.
  - Then start DIV and pull `rst_n` low at cycle 10 → all outputs 0 next cycle.
  - A subsequent MULTU 3×4 gives lo=12.
- **MTHI 0xA5A5A5A5, then MTLO 0x5A5A5A5A:** each register is updated one cycle after its start; the other register is unchanged; `done` pulses; `busy` stays 0.
  - Reserved oper 110 → no `done`.
  - Repeat MULT/DIV signed cases with WIDTH=8 (e.g. −128 / −1 → lo=0x80, hi=0).
